// File: rtl/data_memory_sized_pkg.sv
// Shared definitions for the sized RISC-V data memory.
//   - funct3 encodings for the load/store widths
//   - clear-sweep state enum
//   - access-size typedef and the helper that decodes it from funct3
//   - fault-cause codes reported internally by the lane aligner and top
package data_memory_sized_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_NONE
  } size_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_RANGE    = 2'd1;
  localparam logic [1:0] FC_MISALIGN = 2'd2;
  localparam logic [1:0] FC_ILLEGAL  = 2'd3;

  // SZ_NONE marks the reserved encodings 011, 110 and 111.
  function automatic size_e f3_size(input logic [2:0] f3);
    size_e s;
    s = SZ_NONE;
    case (f3)
      F3_B, F3_BU: s = SZ_BYTE;
      F3_H, F3_HU: s = SZ_HALF;
      F3_W:        s = SZ_WORD;
      default:     s = SZ_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bus between the LSU (master) and the data memory (slave).
//   req_valid/req_ready  : request handshake, accept when both high at clk edge
//   req_we               : 1 = store, 0 = load
//   req_addr             : byte address (ADDR_W bits)
//   req_funct3           : RISC-V width/sign code
//   req_wdata            : right-aligned store data
//   rsp_valid            : one-cycle pulse per accepted request, in order
//   rsp_rdata            : extended load data, 0 for stores and faults
//   rsp_fault            : request was misaligned, out of range or illegal
interface data_memory_sized_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/data_memory_sized_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   funct3      in   request width/sign code
//   we          in   1 = store
//   byte_off    in   addr[1:0]
//   store_data  in   right-aligned store data
//   load_word   in   raw 32-bit word read from the array
//   wmask       out  byte-lane write enables for a store
//   wdata       out  store data replicated onto every candidate lane
//   load_data   out  selected lane, sign- or zero-extended
//   fault_cause out  FC_NONE, FC_MISALIGN or FC_ILLEGAL
module data_memory_sized_lane_align
  import data_memory_sized_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [1:0]  fault_cause
);

  size_e       size;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    size        = f3_size(funct3);
    lane8       = load_word[{byte_off, 3'b000} +: 8];
    lane16      = byte_off[1] ? load_word[31:16] : load_word[15:0];
    wmask       = 4'b0000;
    wdata       = store_data;
    load_data   = 32'h0;
    fault_cause = FC_NONE;

    // funct3[2] distinguishes the zero-extending variants BU/HU.
    case (size)
      SZ_BYTE: begin
        wmask     = 4'b0001 << byte_off;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'h0, lane8} : {{24{lane8[7]}}, lane8};
      end
      SZ_HALF: begin
        wmask     = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {16'h0, lane16} : {{16{lane16[15]}}, lane16};
        if (byte_off[0]) fault_cause = FC_MISALIGN;
      end
      SZ_WORD: begin
        wmask     = 4'b1111;
        load_data = load_word;
        if (byte_off != 2'b00) fault_cause = FC_MISALIGN;
      end
      default: fault_cause = FC_ILLEGAL;
    endcase

    // Unsigned widths only make sense for loads.
    if (we && funct3[2]) fault_cause = FC_ILLEGAL;
  end

endmodule

// File: rtl/data_memory_sized.sv
// Sized RISC-V data memory: byte/half/word loads and stores with
// valid/ready handshake, 1- or 2-cycle read latency and fault reporting.
//   clk    in     rising-edge clock
//   reset  in     synchronous, active-high reset
//   bus    slave  request/response bus (data_memory_sized_if)
// Optional feature: define DMEM_CLEAR_ON_RESET_EN to sweep zeros into every
// word after reset (req_ready low for DEPTH_WORDS cycles). Without it the
// block is ready the first cycle after reset and contents are retained.
module data_memory_sized
  import data_memory_sized_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_sized_if.slave bus
);

  localparam int                IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   SPAN  = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic              req_ready;
  logic              accept;
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [IDX_W-1:0]  req_idx;
  logic [31:0]       rd_word;
  logic [3:0]        lane_wmask;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_load;
  logic [1:0]        lane_cause;
  logic [1:0]        fault_cause;
  logic              fault;

  logic              sweep_active;
  logic [IDX_W-1:0]  sweep_idx;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_wdata;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_rdata_q, s1_rdata_d;
  logic        s1_fault_q, s1_fault_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_rdata_q, s2_rdata_d;
  logic        s2_fault_q, s2_fault_d;

`ifdef DMEM_CLEAR_ON_RESET_EN
  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      ST_CLEAR: begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  // Reset during the sweep restarts it from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  assign req_ready    = (state_q == ST_READY);
  assign sweep_active = (state_q == ST_CLEAR);
  assign sweep_idx    = sweep_idx_q;
`else
  assign req_ready    = 1'b1;
  assign sweep_active = 1'b0;
  assign sweep_idx    = '0;
`endif

  // Offset is exact only when addr >= BASE, which in_range also requires;
  // the extra top bit keeps the span comparison from overflowing.
  always_comb begin
    offset      = bus.req_addr - BASE;
    in_range    = (bus.req_addr >= BASE) && ({1'b0, offset} < SPAN);
    req_idx     = offset[IDX_W+1:2];
    rd_word     = mem_q[req_idx];
    accept      = bus.req_valid && req_ready && !reset;
    fault_cause = in_range ? lane_cause : FC_RANGE;
    fault       = (fault_cause != FC_NONE);
  end

  data_memory_sized_lane_align u_lane_align (
    .funct3      (bus.req_funct3),
    .we          (bus.req_we),
    .byte_off    (bus.req_addr[1:0]),
    .store_data  (bus.req_wdata),
    .load_word   (rd_word),
    .wmask       (lane_wmask),
    .wdata       (lane_wdata),
    .load_data   (lane_load),
    .fault_cause (lane_cause)
  );

  // The sweep and accepted requests never coincide since req_ready is low
  // throughout the sweep.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_mask  = lane_wmask;
    mem_wdata = lane_wdata;
    if (sweep_active) begin
      mem_we    = 1'b1;
      mem_idx   = sweep_idx;
      mem_mask  = 4'b1111;
      mem_wdata = 32'h0;
    end else if (accept && bus.req_we && !fault) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Data/fault registers update only with a new response so the outputs
  // hold their last value between pulses.
  always_comb begin
    s1_valid_d = accept;
    s1_rdata_d = s1_rdata_q;
    s1_fault_d = s1_fault_q;
    if (accept) begin
      s1_fault_d = fault;
      s1_rdata_d = (fault || bus.req_we) ? 32'h0 : lane_load;
    end
    s2_valid_d = s1_valid_q;
    s2_rdata_d = s1_valid_q ? s1_rdata_q : s2_rdata_q;
    s2_fault_d = s1_valid_q ? s1_fault_q : s2_fault_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_rdata_q <= 32'h0;
      s1_fault_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_rdata_q <= 32'h0;
      s2_fault_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rdata_q <= s1_rdata_d;
      s1_fault_q <= s1_fault_d;
      s2_valid_q <= s2_valid_d;
      s2_rdata_q <= s2_rdata_d;
      s2_fault_q <= s2_fault_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (READ_LATENCY == 2) ? s2_valid_q : s1_valid_q;
  assign bus.rsp_rdata = (READ_LATENCY == 2) ? s2_rdata_q : s1_rdata_q;
  assign bus.rsp_fault = (READ_LATENCY == 2) ? s2_fault_q : s1_fault_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (DEPTH_WORDS=16, BASE_ADDR=0,
// READ_LATENCY=2). Each request pushes its expected response onto a queue;
// a negedge monitor pops and compares when rsp_valid pulses, and also flags
// responses that arrive late, never arrive, or arrive unrequested.
module tb_data_memory_sized;
  import data_memory_sized_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  exp_t miss_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_sized_if #(.ADDR_W(32)) bus ();

  data_memory_sized #(
    .DEPTH_WORDS  (DEPTH),
    .ADDR_W       (32),
    .BASE_ADDR    (BASE),
    .READ_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    compared++;
    assert (exp_q.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL unexpected_rsp: observed rsp_valid=1 expected no response pending");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkValue({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
      checkValue({e.tag, "_fault"}, {31'h0, bus.rsp_fault}, {31'h0, e.fault});
      checkValue({e.tag, "_latency"}, 32'(cyc - e.cyc + 1), 32'(LAT));
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      checkOutput();
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc + LAT - 1) begin
      miss_e = exp_q.pop_front();
      checkValue({miss_e.tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'd1);
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input logic exp_flt, input logic expect_rsp, input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
    while (bus.req_ready !== 1'b1 && waited < 4 * DEPTH + 20) begin
      @(negedge clk);
      waited++;
    end
    checkValue({tag, "_ready"}, {31'h0, bus.req_ready}, 32'd1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
    end else if (expect_rsp) begin
      e.rdata = exp_rd;
      e.fault = exp_flt;
      e.cyc   = cyc + 1;
      e.tag   = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic applyReset(input int n);
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic countSweep(input string tag);
    int lowcnt;
    lowcnt = 0;
    while (bus.req_ready !== 1'b1 && lowcnt < 4 * DEPTH) begin
      @(negedge clk);
      lowcnt++;
    end
    checkValue(tag, 32'(lowcnt), 32'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] persist_c;
    logic [31:0] persist_8;
`ifdef DMEM_CLEAR_ON_RESET_EN
    persist_c = 32'h0;
    persist_8 = 32'h0;
`else
    persist_c = 32'h55AA55AA;
    persist_8 = 32'h7FFEF00D;
`endif
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
`ifdef DMEM_CLEAR_ON_RESET_EN
    checkValue("rst_ready", {31'h0, bus.req_ready}, 32'd0);
`else
    checkValue("rst_ready", {31'h0, bus.req_ready}, 32'd1);
`endif
    checkValue("rst_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkValue("rst_rdata", bus.rsp_rdata, 32'h0);
    checkValue("rst_fault", {31'h0, bus.rsp_fault}, 32'd0);

    // Word store/load
    applyStimulus(1'b1, 32'h0, F3_W, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, "sw0");
    applyStimulus(1'b0, 32'h0, F3_W, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "lw0");

    // Byte store into existing word, signed/unsigned byte loads
    applyStimulus(1'b1, 32'h4, F3_W,  32'h11223344, 32'h0, 1'b0, 1'b1, "sw4");
    applyStimulus(1'b1, 32'h5, F3_B,  32'h00000080, 32'h0, 1'b0, 1'b1, "sb5");
    applyStimulus(1'b0, 32'h5, F3_B,  32'h0, 32'hFFFFFF80, 1'b0, 1'b1, "lb5");
    applyStimulus(1'b0, 32'h5, F3_BU, 32'h0, 32'h00000080, 1'b0, 1'b1, "lbu5");
    applyStimulus(1'b0, 32'h4, F3_W,  32'h0, 32'h11228044, 1'b0, 1'b1, "lw4");

    // Half store/loads, misaligned half leaves memory untouched
    applyStimulus(1'b1, 32'h2, F3_H,  32'h0000BEEF, 32'h0, 1'b0, 1'b1, "sh2");
    applyStimulus(1'b0, 32'h2, F3_H,  32'h0, 32'hFFFFBEEF, 1'b0, 1'b1, "lh2");
    applyStimulus(1'b0, 32'h2, F3_HU, 32'h0, 32'h0000BEEF, 1'b0, 1'b1, "lhu2");
    applyStimulus(1'b0, 32'h1, F3_H,  32'h0, 32'h0, 1'b1, 1'b1, "lh1_misalign");
    applyStimulus(1'b0, 32'h0, F3_W,  32'h0, 32'hBEEFBEEF, 1'b0, 1'b1, "lw0_after_sh");

    // Outputs hold between pulses
    idleCycles(4);
    checkValue("hold_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkValue("hold_rdata", bus.rsp_rdata, 32'hBEEFBEEF);
    checkValue("hold_fault", {31'h0, bus.rsp_fault}, 32'd0);

    // Faults: range, misaligned word, reserved funct3, unsigned store
    applyStimulus(1'b0, BASE + 32'(4 * DEPTH), F3_W, 32'h0, 32'h0, 1'b1, 1'b1, "lw_range");
    applyStimulus(1'b1, 32'h3, F3_W,  32'h12345678, 32'h0, 1'b1, 1'b1, "sw3_misalign");
    applyStimulus(1'b0, 32'h0, 3'b011, 32'h0, 32'h0, 1'b1, 1'b1, "f3_011");
    applyStimulus(1'b1, 32'h4, F3_HU, 32'h0000FFFF, 32'h0, 1'b1, 1'b1, "shu_illegal");
    applyStimulus(1'b0, 32'h4, F3_W,  32'h0, 32'h11228044, 1'b0, 1'b1, "lw4_unchanged");

    // Eight back-to-back mixed requests
    applyStimulus(1'b1, 32'h8,  F3_W,  32'hCAFEF00D, 32'h0, 1'b0, 1'b1, "b2b_sw8");
    applyStimulus(1'b0, 32'h8,  F3_W,  32'h0, 32'hCAFEF00D, 1'b0, 1'b1, "b2b_lw8");
    applyStimulus(1'b0, 32'h8,  F3_B,  32'h0, 32'h0000000D, 1'b0, 1'b1, "b2b_lb8");
    applyStimulus(1'b0, 32'hA,  F3_H,  32'h0, 32'hFFFFCAFE, 1'b0, 1'b1, "b2b_lhA");
    applyStimulus(1'b1, 32'hB,  F3_B,  32'h0000007F, 32'h0, 1'b0, 1'b1, "b2b_sbB");
    applyStimulus(1'b0, 32'h8,  F3_W,  32'h0, 32'h7FFEF00D, 1'b0, 1'b1, "b2b_lw8b");
    applyStimulus(1'b0, 32'h8,  F3_HU, 32'h0, 32'h0000F00D, 1'b0, 1'b1, "b2b_lhu8");
    applyStimulus(1'b0, 32'h44, F3_W,  32'h0, 32'h0, 1'b1, 1'b1, "b2b_range");
    idleCycles(4);

    // Reset with a load in flight: response dropped, stores retained
    applyStimulus(1'b1, 32'hC, F3_W, 32'h55AA55AA, 32'h0, 1'b0, 1'b1, "sw_c");
    applyStimulus(1'b0, 32'hC, F3_W, 32'h0, 32'h0, 1'b0, 1'b0, "lw_c_dropped");
    applyReset(1);
    idleCycles(4);
    checkValue("rst_drop_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkValue("rst_drop_rdata", bus.rsp_rdata, 32'h0);
    applyStimulus(1'b0, 32'hC, F3_W, 32'h0, persist_c, 1'b0, 1'b1, "lw_c_persist");
    applyStimulus(1'b0, 32'h8, F3_W, 32'h0, persist_8, 1'b0, 1'b1, "lw_8_persist");
    idleCycles(4);

`ifdef DMEM_CLEAR_ON_RESET_EN
    // Clear sweep after reset, and restart of a sweep interrupted at index 10
    applyStimulus(1'b1, 32'h3C, F3_W, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, "sw_3c");
    idleCycles(4);
    applyReset(1);
    countSweep("sweep_len");
    applyStimulus(1'b0, 32'h3C, F3_W, 32'h0, 32'h0, 1'b0, 1'b1, "lw_3c_cleared");
    applyStimulus(1'b0, 32'h10, F3_W, 32'h0, 32'h0, 1'b0, 1'b1, "lw_10_cleared");
    idleCycles(4);
    applyReset(1);
    repeat (10) @(negedge clk);
    checkValue("mid_sweep_ready", {31'h0, bus.req_ready}, 32'd0);
    applyReset(1);
    countSweep("sweep_restart_len");
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checkValue("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
